multicycle_control: RTL and testbench

// - Sequencing controller for the multicycle MIPS datapath variant: one FSM steps each instruction through

---
 rtl/multicycle_control_pkg.sv | 55 +++++
 rtl/multicycle_control_alu_decoder.sv | 24 ++
 rtl/multicycle_control.sv | 173 +++++++++++++++++
 tb/tb_multicycle_control.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS controller:
// states, opcodes, funct codes, ALU ops and mux selects.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_FAULT  = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // States that wait on the shared memory handshake
    function automatic logic is_mem_state(state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// R-type funct to ALU operation decode, with a
// flag that marks unsupported funct codes.
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o,
    output logic       funct_valid_o
);

    always_comb begin
        alu_control_o = ALU_AND;
        funct_valid_o = 1'b1;
        case (funct_i)
            FN_ADD:  alu_control_o = ALU_ADD;
            FN_SUB:  alu_control_o = ALU_SUB;
            FN_AND:  alu_control_o = ALU_AND;
            FN_OR:   alu_control_o = ALU_OR;
            FN_SLT:  alu_control_o = ALU_SLT;
            default: funct_valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing FSM with a memory
// handshake watchdog; outputs decode from state.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       instr_retired,
    output logic       fault,
    output logic [3:0] state_dbg
);

    state_e            state_q, state_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [2:0]        rt_alu;
    logic              funct_ok;
    logic              waiting;
    logic              timed_out;

    alu_decoder u_alu_dec (
        .funct_i       (funct),
        .alu_control_o (rt_alu),
        .funct_valid_o (funct_ok)
    );

    assign waiting   = is_mem_state(state_q) && !mem_ready;
    assign timed_out = waiting && (to_q == TO_W'(MEM_TIMEOUT));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:       state_d = S_RTEX;
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:        state_d = S_ADDIEX;
                    OP_J:           state_d = S_JUMP;
                    default:        state_d = S_FAULT;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_RTEX:   state_d = funct_ok ? S_ALUWB : S_FAULT;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH,
            S_ADDIWB, S_JUMP: state_d = S_FETCH;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
        endcase
        if (timed_out) state_d = S_FAULT;
    end

    always_comb begin
        if (state_d != state_q) to_d = '0;
        else if (waiting)       to_d = to_q + TO_W'(1);
        else                    to_d = to_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
        end
    end

    // Everything is held low during reset, even though state is FETCH
    always_comb begin
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_en         = 1'b0;
        pc_src        = PC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_control   = ALU_AND;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        instr_retired = 1'b0;
        fault         = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_req     = 1'b1;
                    alu_src_b   = SRCB_FOUR;
                    alu_control = ALU_ADD;
                    ir_write    = mem_ready;
                    pc_en       = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b   = SRCB_IMM_SH;
                    alu_control = ALU_ADD;
                end
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = SRCB_IMM;
                    alu_control = ALU_ADD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    reg_write     = 1'b1;
                    mem_to_reg    = 1'b1;
                    instr_retired = 1'b1;
                end
                S_MEMWR: begin
                    mem_req       = 1'b1;
                    mem_write     = 1'b1;
                    iord          = 1'b1;
                    instr_retired = mem_ready;
                end
                S_RTEX: begin
                    alu_src_a   = 1'b1;
                    alu_control = rt_alu;
                end
                S_ALUWB: begin
                    reg_write     = 1'b1;
                    reg_dst       = 1'b1;
                    instr_retired = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_control   = ALU_SUB;
                    pc_src        = PC_ALUOUT;
                    pc_en         = zero ^ opcode[0];
                    instr_retired = 1'b1;
                end
                S_ADDIWB: begin
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                S_JUMP: begin
                    pc_src        = PC_JUMP;
                    pc_en         = 1'b1;
                    instr_retired = 1'b1;
                end
                S_FAULT: fault = 1'b1;
                default: fault = 1'b1;
            endcase
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream against a per-instruction
// cycle-table model of the multicycle controller.
module tb_multicycle_control;

    localparam int TMO = 15;
    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3;
    localparam int MEMWB = 4, MEMWR = 5, RTEX = 6, ALUWB = 7;
    localparam int BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11;
    localparam int FLT = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic [5:0] opcode, funct;
    logic zero, mem_ready;
    logic mem_req, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_src, alu_src_b;
    logic alu_src_a;
    logic [2:0] alu_control;
    logic reg_dst, mem_to_reg, reg_write, instr_retired, fault;
    logic [3:0] state_dbg;
    logic [21:0] obs;

    multicycle_control #(.MEM_TIMEOUT(TMO), .TO_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .instr_retired(instr_retired),
        .fault(fault), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign obs = {state_dbg, mem_req, mem_write, iord, ir_write, pc_en,
                  pc_src, alu_src_a, alu_src_b, alu_control,
                  reg_dst, mem_to_reg, reg_write, instr_retired, fault};

    typedef struct { int st; bit rdy; bit z; } step_t;
    step_t q[$];
    int vectors = 0, miscompares = 0;
    int exp_ret = 0, dut_ret = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    function automatic bit fn_ok(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100,
                         6'b100101, 6'b101010};
    endfunction

    // Zero-wait cycle count of each instruction class
    function automatic int base_lat(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            default: return 3;
        endcase
    endfunction

    // Expected outputs in one cycle of a given step
    function automatic logic [21:0] exp_of(input step_t s,
                                           input logic [5:0] op,
                                           input logic [5:0] fn);
        logic rq = 0, mw = 0, io = 0, irw = 0, pe = 0, a = 0;
        logic rd = 0, m2r = 0, rw = 0, rt = 0, f = 0;
        logic [1:0] ps = 0, b = 0;
        logic [2:0] al = 0;
        case (s.st)
            FETCH: begin
                rq = 1; b = 2'b01; al = 3'b010; irw = s.rdy; pe = s.rdy;
            end
            DECODE: begin b = 2'b11; al = 3'b010; end
            MEMADR, ADDIEX: begin a = 1; b = 2'b10; al = 3'b010; end
            MEMRD: begin rq = 1; io = 1; end
            MEMWB: begin rw = 1; m2r = 1; rt = 1; end
            MEMWR: begin rq = 1; mw = 1; io = 1; rt = s.rdy; end
            RTEX: begin a = 1; al = alu_of(fn); end
            ALUWB: begin rw = 1; rd = 1; rt = 1; end
            BRANCH: begin
                a = 1; al = 3'b110; ps = 2'b01; pe = s.z ^ op[0]; rt = 1;
            end
            ADDIWB: begin rw = 1; rt = 1; end
            JUMP: begin ps = 2'b10; pe = 1; rt = 1; end
            FLT: f = 1;
            default: f = 1;
        endcase
        return {4'(s.st), rq, mw, io, irw, pe, ps, a, b, al,
                rd, m2r, rw, rt, f};
    endfunction

    task automatic push(input int st, input bit rdy, input bit z);
        step_t s;
        s.st = st; s.rdy = rdy; s.z = z;
        q.push_back(s);
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // A memory wait of w cycles; beyond the timeout it ends in FAULT
    task automatic add_mem(input int st, input int w, inout bit dead);
        for (int i = 0; i < w && i <= TMO; i++) push(st, 0, rb());
        if (w > TMO) begin
            dead = 1;
            for (int i = 0; i < 3; i++) push(FLT, rb(), rb());
        end else push(st, 1, rb());
    endtask

    task automatic build(input logic [5:0] op, input logic [5:0] fn,
                         input bit z, input int wf, input int wm,
                         output bit dead);
        bit d = 0;
        q.delete();
        add_mem(FETCH, wf, d);
        if (!d) begin
            push(DECODE, rb(), rb());
            case (op)
                6'b100011: begin
                    push(MEMADR, rb(), rb());
                    add_mem(MEMRD, wm, d);
                    if (!d) push(MEMWB, rb(), rb());
                end
                6'b101011: begin
                    push(MEMADR, rb(), rb());
                    add_mem(MEMWR, wm, d);
                end
                6'b000000: begin
                    push(RTEX, rb(), rb());
                    if (fn_ok(fn)) push(ALUWB, rb(), rb());
                    else begin
                        d = 1;
                        for (int i = 0; i < 3; i++) push(FLT, rb(), rb());
                    end
                end
                6'b000100, 6'b000101: push(BRANCH, rb(), z);
                6'b001000: begin
                    push(ADDIEX, rb(), rb());
                    push(ADDIWB, rb(), rb());
                end
                6'b000010: push(JUMP, rb(), rb());
                default: begin
                    d = 1;
                    for (int i = 0; i < 3; i++) push(FLT, rb(), rb());
                end
            endcase
        end
        dead = d;
    endtask

    // keep < 0 runs the whole instruction; otherwise the first keep cycles
    task automatic run(input string tag, input logic [5:0] op,
                       input logic [5:0] fn, input bit z,
                       input int wf, input int wm, input int keep);
        bit dead;
        int n, lat = 0;
        build(op, fn, z, wf, wm, dead);
        n = (keep < 0) ? q.size() : keep;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin opcode = op; funct = fn; end
            mem_ready = q[i].rdy;
            zero = q[i].z;
            #1;
            chk(tag, {10'b0, obs}, {10'b0, exp_of(q[i], op, fn)});
            if (instr_retired) begin
                dut_ret++;
                if (lat == 0) lat = i + 1;
            end
        end
        if (keep < 0 && !dead) begin
            exp_ret++;
            chk({tag, "_lat"}, lat, base_lat(op) + wf +
                ((op == 6'b100011 || op == 6'b101011) ? wm : 0));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        mem_ready = 1;
        #1;
        chk("rst_outs", {10'b0, obs}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    logic [5:0] ops[7];
    logic [5:0] fns[5];
    int r0;

    initial begin
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b000101, 6'b001000, 6'b000010};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        rst_n = 0; opcode = 0; funct = 0; zero = 0; mem_ready = 1;
        #1;
        chk("reset_state", {10'b0, obs}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;

        run("lw_fast", 6'b100011, 6'h00, 0, 0, 0, -1);
        run("lw_fwait", 6'b100011, 6'h00, 0, 3, 0, -1);
        run("bne_nz", 6'b000101, 6'h00, 0, 0, 0, -1);
        run("bne_z", 6'b000101, 6'h00, 1, 0, 0, -1);
        run("beq_nz", 6'b000100, 6'h00, 0, 0, 0, -1);
        run("beq_z", 6'b000100, 6'h00, 1, 0, 0, -1);
        run("lw_tmo_ok", 6'b100011, 6'h00, 0, 0, TMO, -1);
        run("sw_tmo_ok", 6'b101011, 6'h00, 0, TMO, TMO, -1);

        for (int k = 0; k < 60; k++) begin
            int sel = $urandom_range(0, 6);
            run("rand", ops[sel], fns[$urandom_range(0, 4)], rb(),
                $urandom_range(0, 4), $urandom_range(0, 4), -1);
        end

        r0 = dut_ret;
        for (int i = 0; i < 4; i++) begin
            run("loop_addi", 6'b001000, 6'h00, 0, 0, 0, -1);
            run("loop_bne", 6'b000101, 6'h00, (i == 3), 0, 0, -1);
        end
        run("loop_j", 6'b000010, 6'h00, 0, 0, 0, -1);
        chk("loop_ret", dut_ret - r0, 9);

        run("lw_tmo_flt", 6'b100011, 6'h00, 0, 0, TMO + 1, -1);
        do_reset();
        run("fetch_tmo", 6'b001000, 6'h00, 0, TMO + 1, 0, -1);
        do_reset();
        run("bad_op", 6'b111111, 6'h00, 0, 0, 0, -1);
        do_reset();
        run("bad_fn", 6'b000000, 6'h00, 0, 1, 0, -1);
        do_reset();
        run("sw_cut", 6'b101011, 6'h00, 0, 0, 6, 6);
        do_reset();
        run("post_rst", 6'b100011, 6'h00, 0, 0, 0, -1);
        run("post_rst2", 6'b000000, 6'b101010, 0, 2, 0, -1);

        chk("ret_total", dut_ret, exp_ret);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
